seqgen_sched: RTL and testbench
===============================

SEQGEN_SCHED -- requirements
Module: seqgen_sched

Interface
REQ-001 Parameter DATA_W, default 4: width of the sequence generator output word.
REQ-002 Parameter LEN_W, default 4: width of each requester's burst-length field.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  2  per-requester burst request, level, held until grant completes.
REQ-006 len0  input  LEN_W  requester 0 burst length in generator steps; 0 means 2^LEN_W.
REQ-007 len1  input  LEN_W  requester 1 burst length; same encoding.
REQ-008 gen_out  input  DATA_W  current output of the shared sequence generator.
REQ-009 gen_en  output  1  step enable to the shared generator.
REQ-010 gen_nrst  output  1  active-low clear to the shared generator.
REQ-011 gnt  output  2  one-hot grant; at most one bit high.
REQ-012 dout  output  DATA_W  registered copy of gen_out for the granted requester.
REQ-013 dout_valid  output  2  one-hot; qualifies dout for the granted requester.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, CLEAR, RUN and DONE.
REQ-016 In IDLE with req != 0, the block SHALL select a winner, assert its gnt bit, latch its length minus 1 (mod 2^LEN_W) into the step counter, and go to CLEAR on the next edge.
REQ-017 Arbitration SHALL be round-robin: when both requesters request, the one not granted last wins; after reset, requester 0 has priority.
REQ-018 CLEAR SHALL last exactly one cycle with gen_nrst=0 and gen_en=0, then go to RUN.
REQ-019 In RUN, gen_en SHALL be 1 each cycle; the counter decrements each cycle; the state goes to DONE on the edge where the counter is 0, giving exactly len (or 2^LEN_W) enabled cycles.
REQ-020 On every edge where gen_en=1, dout SHALL load gen_out, and dout_valid SHALL assert the granted bit for the following cycle; dout_valid is otherwise 0.
REQ-021 DONE SHALL last one cycle with gen_en=0, holding gnt; on exit, gnt clears, the round-robin pointer records the winner, and the state returns to IDLE.
REQ-022 If the granted req bit drops during CLEAR or RUN, the block SHALL go to DONE on the next edge (abort); a req change during DONE is ignored.
REQ-023 gnt SHALL remain stable from IDLE exit through DONE; len inputs are sampled only at grant.
REQ-024 Outside CLEAR, gen_nrst SHALL be 1; outside RUN, gen_en SHALL be 0.
REQ-025 A new grant SHALL NOT start in the same cycle as DONE; the minimum gap between bursts is one IDLE cycle.

Reset
REQ-026 While rst is high, the state SHALL be IDLE, gnt=0, dout=0, dout_valid=0, gen_en=0, gen_nrst=0, busy=0, counter=0, and the pointer SHALL favour requester 0.
REQ-027 Assertion of rst mid-burst SHALL abort immediately without a DONE cycle; after release, gen_nrst returns to 1 on the first edge.

Structure
REQ-028 The FSM state encoding and the DATA_W/LEN_W defaults SHALL live in a shared package, seqgen_pkg.
REQ-029 The round-robin selector SHALL be a sub-module, rr_arb2 (inputs req and last-winner; output one-hot grant), which is purely combinational; the FSM, counter and output registers stay in seqgen_sched.

Verification
REQ-030 rst high, then low; req=01, len0=3 -> gnt=01 next cycle, one CLEAR cycle with gen_nrst=0, exactly 3 gen_en cycles, 3 dout_valid=01 pulses, DONE, IDLE.
REQ-031 req=11 held continuously, len0=len1=2 -> grant order 01, 10, 01, each burst 2 steps, with one IDLE cycle between bursts.
REQ-032 req=10, len1=0 -> 16 consecutive gen_en cycles and 16 dout_valid=10 cycles.
REQ-033 req=01, len0=8, then drop req[0] after 3 RUN cycles -> DONE on the next edge, 3 or 4 valid words only, gnt cleared, and the pointer favours requester 1.
REQ-034 rst asserted during RUN -> same cycle gnt=0, gen_en=0, dout_valid=0, busy=0; after release, req=10 alone is granted normally.
REQ-035 Bench model of a 4-bit up-counter generator -> dout SHALL follow 1,2,3,... after each CLEAR for every burst.

Source files
------------

// File: rtl/seqgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seqgen_pkg
//  Description : Shared width defaults, FSM state encoding and a small
//                grant helper for the sequence-generator scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package seqgen_pkg;

    localparam int c_DATA_W = 4;
    localparam int c_LEN_W  = 4;
    localparam int c_ST_W   = 2;

    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index of the requester owning a one-hot 2-bit grant.
    function automatic logic gnt_idx(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin selector, purely combinational. A lone
//                requester wins outright; on contention the requester that
//                did not win last time is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,   // index of the previous winner
    output logic [1:0] o_gnt
);

    // One-hot winner selection from the request vector and last winner.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seqgen_sched.sv
`default_nettype none
// ============================================================================
//  Module      : seqgen_sched
//  Description : Schedules bursts of a shared sequence generator between two
//                requesters. Each burst clears the generator for one cycle,
//                steps it a programmed number of times and returns the
//                generator words to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module seqgen_sched
    import seqgen_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] gen_out,
    output logic              gen_en,
    output logic              gen_nrst,
    output logic [1:0]        gnt,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        dout_valid,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_gnt;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_last;
    logic [DATA_W-1:0]  r_dout;
    logic [1:0]         r_dout_valid;
    logic               r_gen_nrst;
    logic [1:0]         w_arb_gnt;
    logic [LEN_W-1:0]   w_len_sel;
    logic               w_req_held;
    logic               w_gen_en;

    rr_arb2 u_arb (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt)
    );

    // Length of the would-be winner; 0 wraps to all-ones after the -1.
    assign w_len_sel  = w_arb_gnt[1] ? len1 : len0;
    // The granted requester is still asking for its burst.
    assign w_req_held = |(req & r_gnt);
    assign w_gen_en   = (r_state == ST_RUN);

    // Next-state decode; a dropped request in CLEAR/RUN aborts to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = w_req_held ? ST_RUN : ST_DONE;
            ST_RUN:   if (!w_req_held || (r_cnt == '0)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, grant, step counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_cnt   <= '0;
            r_last  <= 1'b1;    // last winner = 1, so requester 0 is favoured
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt <= w_arb_gnt;
                        r_cnt <= w_len_sel - LEN_W'(1);
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - LEN_W'(1);
                end
                ST_DONE: begin
                    r_gnt  <= 2'b00;
                    r_last <= gnt_idx(r_gnt);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Generator clear is registered so it is low throughout reset and
    // lines up exactly with the CLEAR state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen_nrst <= 1'b0;
        end else begin
            r_gen_nrst <= (w_state_nxt != ST_CLEAR);
        end
    end

    // Capture each generator step and flag it for the granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 2'b00;
        end else begin
            if (w_gen_en) begin
                r_dout <= gen_out;
            end
            r_dout_valid <= w_gen_en ? r_gnt : 2'b00;
        end
    end

    assign gen_en     = w_gen_en;
    assign gen_nrst   = r_gen_nrst;
    assign gnt        = r_gnt;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seqgen_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seqgen_sched
//  Description : Directed self-checking bench for seqgen_sched with a 4-bit
//                up-counter generator model stepping on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seqgen_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [3:0] gen_out;
    logic       gen_en;
    logic       gen_nrst;
    logic [1:0] gnt;
    logic [3:0] dout;
    logic [1:0] dout_valid;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] r_gen;

    seqgen_sched #(.DATA_W(4), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .gen_out    (gen_out),
        .gen_en     (gen_en),
        .gen_nrst   (gen_nrst),
        .gnt        (gnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model: counts on the falling edge so a fresh value is
    // present at each rising edge where the scheduler captures it.
    always @(negedge clk) begin
        if (!gen_nrst)    r_gen <= 4'd0;
        else if (gen_en)  r_gen <= r_gen + 4'd1;
    end
    assign gen_out = r_gen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant edge, CLEAR, n RUN cycles; returns with the DUT in DONE.
    task automatic burst(input logic [1:0] eg, input int n);
        tick();
        chk("grant_gnt", {30'd0, gnt}, {30'd0, eg});
        chk("clear_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("clear_en", {31'd0, gen_en}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        tick();
        for (int i = 1; i <= n; i++) begin
            chk("run_en", {31'd0, gen_en}, 32'd1);
            chk("run_nrst", {31'd0, gen_nrst}, 32'd1);
            tick();
            chk("dout", {28'd0, dout}, {28'd0, 4'(i)});
            chk("valid", {30'd0, dout_valid}, {30'd0, eg});
        end
        chk("done_en", {31'd0, gen_en}, 32'd0);
        chk("done_gnt", {30'd0, gnt}, {30'd0, eg});
        chk("done_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic chk_idle();
        chk("idle_gnt", {30'd0, gnt}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {30'd0, dout_valid}, 32'd0);
        chk("idle_en", {31'd0, gen_en}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        len0 = 4'd0;
        len1 = 4'd0;
        tick();
        tick();
        // Reset state
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_dout", {28'd0, dout}, 32'd0);
        chk("rst_valid", {30'd0, dout_valid}, 32'd0);
        chk("rst_en", {31'd0, gen_en}, 32'd0);
        chk("rst_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_nrst", {31'd0, gen_nrst}, 32'd1);
        chk_idle();

        // Single requester 0, three steps
        req  = 2'b01;
        len0 = 4'd3;
        burst(2'b01, 3);
        req = 2'b00;
        tick();
        chk_idle();

        // Requester 1 alone, length 0 means sixteen steps
        req  = 2'b10;
        len1 = 4'd0;
        burst(2'b10, 16);
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd2;
        tick();
        chk_idle();

        // Contention: alternating grants with one IDLE cycle between
        burst(2'b01, 2);
        tick();
        chk_idle();
        burst(2'b10, 2);
        tick();
        chk_idle();
        burst(2'b01, 2);
        req = 2'b00;
        tick();
        chk_idle();

        // Abort: requester 0 drops its request in the fourth RUN cycle
        req  = 2'b01;
        len0 = 4'd8;
        tick();
        chk("ab_gnt", {30'd0, gnt}, 32'd1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("ab_dout", {28'd0, dout}, {28'd0, 4'(i)});
            chk("ab_en", {31'd0, gen_en}, 32'd1);
        end
        req = 2'b00;
        tick();
        chk("ab_done_en", {31'd0, gen_en}, 32'd0);
        chk("ab_done_gnt", {30'd0, gnt}, 32'd1);
        chk("ab_done_dout", {28'd0, dout}, 32'd4);
        chk("ab_done_valid", {30'd0, dout_valid}, 32'd1);
        tick();
        chk_idle();

        // After the abort, requester 1 is favoured on contention
        req  = 2'b11;
        len1 = 4'd1;
        burst(2'b10, 1);
        req = 2'b00;
        tick();
        chk_idle();

        // Reset in the middle of a burst
        req  = 2'b01;
        len0 = 4'd5;
        tick();
        tick();
        tick();
        chk("pre_rst_valid", {30'd0, dout_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("mid_rst_en", {31'd0, gen_en}, 32'd0);
        chk("mid_rst_valid", {30'd0, dout_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_dout", {28'd0, dout}, 32'd0);
        tick();
        rst  = 1'b0;
        req  = 2'b10;
        len1 = 4'd2;
        burst(2'b10, 2);
        req = 2'b00;
        tick();
        chk_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
